// File: rtl/live_framer_pkg.sv
// Shared types and constants for the live byte framer.
package live_framer_pkg;

    typedef logic [7:0] byte_t;

    // Control word bit positions; bits [3:2] are reserved.
    localparam int unsigned CTL_EN    = 0;
    localparam int unsigned CTL_FLUSH = 1;

    // Framer FSM encoding.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_SEND = 2'd1;
    localparam state_t ST_GAP  = 2'd2;

endpackage

// File: rtl/live_byte_framer_if.sv
// Frame byte bus: req/ack handshake carrying one byte with sop/eop markers.
//   master: drives bus_req, bus_data, bus_sop, bus_eop; samples bus_ack
//   slave : samples the frame signals; drives bus_ack
interface live_byte_framer_if;
    import live_framer_pkg::*;

    logic  bus_req;
    byte_t bus_data;
    logic  bus_sop;
    logic  bus_eop;
    logic  bus_ack;

    modport master (output bus_req, bus_data, bus_sop, bus_eop, input bus_ack);
    modport slave  (input bus_req, bus_data, bus_sop, bus_eop, output bus_ack);

endinterface

// File: rtl/byte_fifo.sv
// Synchronous FIFO with combinational head read port and synchronous flush.
//   clk, reset_L : clock, async active-low reset
//   push, din    : write request and data (ignored when full unless popping)
//   pop          : read request (ignored when empty)
//   flush        : empties the FIFO; overrides push and pop
//   full_c       : decode of the occupancy register
//   level        : registered occupancy, one bit wider than the pointers
//   head_c       : entry at the read pointer
module byte_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset_L,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    input  logic                       flush,
    output logic                       full_c,
    output logic [$clog2(DEPTH):0]     level,
    output logic [WIDTH-1:0]           head_c
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             empty_c;
    logic             push_ok;
    logic             pop_ok;

    assign full_c  = (level_q == LVL_W'(DEPTH));
    assign empty_c = (level_q == '0);
    assign level   = level_q;
    assign head_c  = mem_q[rd_ptr_q];

    // A pop at full frees the slot the simultaneous push needs.
    always_comb begin
        pop_ok   = pop & ~empty_c & ~flush;
        push_ok  = push & ~flush & (~full_c | pop_ok);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            level_d = level_q + LVL_W'(push_ok) - LVL_W'(pop_ok);
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/live_byte_framer.sv
// Buffers the upstream LIVE_DATA/VALID byte stream and emits fixed-length
// frames on a req/ack byte bus. Upstream has no backpressure, so bytes
// arriving at a full FIFO are dropped and flagged in a sticky overflow bit.
//   clk, reset_L : clock, async active-low reset
//   control      : [0] enable, [1] flush (level), [3:2] reserved
//   live_data    : upstream byte, qualified by valid
//   bus          : frame byte bus (master side)
//   overflow     : sticky drop flag, cleared by flush or reset
//   level        : FIFO occupancy
module live_byte_framer
    import live_framer_pkg::*;
#(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned FRAME_LEN = 4,
    parameter int unsigned GAP       = 2
) (
    input  logic                    clk,
    input  logic                    reset_L,
    input  logic [3:0]              control,
    input  byte_t                   live_data,
    input  logic                    valid,
    live_byte_framer_if.master      bus,
    output logic                    overflow,
    output logic [$clog2(DEPTH):0]  level
);

    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned GAP_W = 4;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             req_q, req_d;
    logic             sop_q, sop_d;
    logic             eop_q, eop_d;
    logic             ovf_q, ovf_d;
    logic             pop;
    logic             flush;
    logic             full_c;
    byte_t            head_c;
    logic             unused_ctl;

    assign unused_ctl = ^control[3:2];
    assign flush      = control[CTL_FLUSH];

    byte_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_fifo (
        .clk     (clk),
        .reset_L (reset_L),
        .push    (valid),
        .din     (live_data),
        .pop     (pop),
        .flush   (flush),
        .full_c  (full_c),
        .level   (level),
        .head_c  (head_c)
    );

    // Frame sequencing, drop detection and flush handling.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        req_d   = req_q;
        sop_d   = sop_q;
        eop_d   = eop_q;
        ovf_d   = ovf_q;
        pop     = 1'b0;
        if (flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            gap_d   = '0;
            req_d   = 1'b0;
            sop_d   = 1'b0;
            eop_d   = 1'b0;
            ovf_d   = 1'b0;
        end else begin
            pop = req_q & bus.bus_ack;
            if (valid & full_c & ~pop) ovf_d = 1'b1;
            case (state_q)
                ST_IDLE: begin
                    // A frame only starts once all of its bytes are buffered.
                    if (control[CTL_EN] && (level >= LVL_W'(FRAME_LEN))) begin
                        state_d = ST_SEND;
                        cnt_d   = '0;
                        req_d   = 1'b1;
                        sop_d   = 1'b1;
                        eop_d   = (FRAME_LEN == 1);
                    end
                end
                ST_SEND: begin
                    if (pop) begin
                        if (eop_q) begin
                            cnt_d = '0;
                            req_d = 1'b0;
                            sop_d = 1'b0;
                            eop_d = 1'b0;
                            if (GAP == 0) begin
                                state_d = ST_IDLE;
                            end else begin
                                state_d = ST_GAP;
                                gap_d   = GAP_W'(GAP - 1);
                            end
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                            sop_d = 1'b0;
                            eop_d = ((cnt_q + CNT_W'(1)) == CNT_W'(FRAME_LEN - 1));
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_q == '0) state_d = ST_IDLE;
                    else             gap_d   = gap_q - GAP_W'(1);
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            gap_q   <= '0;
            req_q   <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            req_q   <= req_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            ovf_q   <= ovf_d;
        end
    end

    // bus_data is the FIFO head, forced to zero whenever no byte is offered.
    assign bus.bus_req  = req_q;
    assign bus.bus_sop  = sop_q;
    assign bus.bus_eop  = eop_q;
    assign bus.bus_data = req_q ? head_c : '0;
    assign overflow     = ovf_q;

endmodule
